// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encoding, bus widths and the prefetch buffer entry layout.
package ifetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;
  localparam int BUF_DEPTH   = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } buf_entry_t;

endpackage

// File: rtl/ifetch_sequencer_if.sv
// Fetch bus: instruction memory port, redirect input, decode handshake.
// master = sequencer side, slave = memory/execute/decode side.
interface ifetch_sequencer_if;
  import ifetch_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/ifetch_buf.sv
// Two-entry prefetch FIFO; flush beats push and pop.
// Ports: push_i/pop_i/flush_i, din_i, head_o, valid_o, count_o.
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  buf_entry_t din_i,
  output buf_entry_t head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  buf_entry_t e0_q, e0_d;
  buf_entry_t e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop_ok;

  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    cnt_d  = cnt_q;
    pop_ok = pop_i & (cnt_q != 2'd0);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_i, pop_ok})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = din_i;
          end else begin
            e0_d = din_i;
          end
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_d  = din_i;
            cnt_d = 2'd1;
          end else if (cnt_q == 2'd1) begin
            e1_d  = din_i;
            cnt_d = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_sequencer.sv
// PC sequencer + FSM feeding a 2-entry prefetch buffer to decode.
// Ports: clk, rst, start, bus (master), busy, done, misalign_err.
// Optional: define FETCH_TRACE_EN to print fetches and redirects.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          PROG_BYTES = 72
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  ifetch_sequencer_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                misalign_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;

  buf_entry_t head;
  logic       head_vld;
  logic [1:0] count;
  logic       pop, redir, fits, fetch, empty_nxt;

  // Legality check done in 33 bits so a wrapped pc+4 is never "in image".
  assign fits  = ({1'b0, pc_q} + 33'd4) <= 33'(PROG_BYTES);
  assign pop   = head_vld & bus.out_ready;
  assign redir = bus.redirect_valid & (state_q != ST_IDLE);
  assign fetch = (state_q == ST_RUN) & ~redir & fits &
                 ((count != 2'd2) | pop);
  assign empty_nxt = (count == 2'd0) | ((count == 2'd1) & pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (redir) begin
      pc_d = bus.redirect_addr;
      if (bus.redirect_addr[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      if (fetch) pc_d = pc_q + 32'(INSTR_BYTES);
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (!fits)
                    state_d = empty_nxt ? ST_DONE : ST_DRAIN;
        ST_DRAIN: if (empty_nxt) state_d = ST_DONE;
        ST_DONE:  if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                  end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  ifetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fetch),
    .pop_i   (pop & ~redir),
    .flush_i (redir),
    .din_i   ('{pc: pc_q, instr: bus.imem_instr}),
    .head_o  (head),
    .valid_o (head_vld),
    .count_o (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = head_vld;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign busy          = (state_q == ST_RUN) |
                         (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign misalign_err  = err_q;

`ifdef FETCH_TRACE_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (fetch)
        $display("[%0d] fetch pc=%0d instr=%b",
                 cyc_q, pc_q, bus.imem_instr);
      if (redir)
        $display("[%0d] redirect %0d -> %0d flush=%0d",
                 cyc_q, pc_q, bus.redirect_addr, count);
    end
  end
`endif

endmodule
